// File: rtl/preadd_arbiter_seq.sv
// preadd_arbiter_seq: two-requester round-robin front end for an A/D pre-adder.
// Define PREADD_ARB_STATS_EN to add saturating per-requester grant counters.
module preadd_arbiter_seq #(
  parameter int PIPE_LAT = 2,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [29:0]      req0_a,
  input  logic [24:0]      req0_d,
  input  logic [1:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [29:0]      req1_a,
  input  logic [24:0]      req1_d,
  input  logic [1:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             hold,
  input  logic             flush,
  output logic             flush_done,
  output logic [29:0]      A,
  output logic [24:0]      D,
  output logic [3:0]       INMODE,
  output logic             CEA2,
  output logic             CED,
  output logic             CEAD,
  output logic             CEA1,
  output logic             res_valid,
  output logic             res_id,
`ifdef PREADD_ARB_STATS_EN
  output logic [TAG_W-1:0] res_tag,
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1
`else
  output logic [TAG_W-1:0] res_tag
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic             v;
    logic             id;
    logic [TAG_W-1:0] tag;
  } trk_t;

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [29:0]      a_q, a_d;
  logic [24:0]      d_q, d_d;
  logic [3:0]       inm_q, inm_d;
  logic             iss_v_q, iss_v_d;
  logic             ced_q, ced_d;
  logic             iss_id_q, iss_id_d;
  logic [TAG_W-1:0] iss_tag_q, iss_tag_d;
  trk_t             trk_q [PIPE_LAT];
  trk_t             trk_d [PIPE_LAT];

  logic       accept;
  logic       gnt0, gnt1, gnt;
  logic [1:0] sel_op;
  logic       pend;

  function automatic logic [3:0] op_inmode(input logic [1:0] op);
    logic [3:0] m;
    unique case (op)
      2'b00:   m = 4'b0000;
      2'b01:   m = 4'b0100;
      2'b10:   m = 4'b1100;
      default: m = 4'b0110;
    endcase
    return m;
  endfunction

  // Round-robin grant; rr_q names the requester favoured on a tie.
  always_comb begin
    accept = (state_q != DRAIN) && !hold && !flush;
    gnt0   = accept && req0_valid
          && (!req1_valid || !rr_q);
    gnt1   = accept && req1_valid
          && (!req0_valid || rr_q);
    gnt    = gnt0 | gnt1;
    sel_op = gnt1 ? req1_op : req0_op;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Ops issuing now or still short of the final tracker stage.
  always_comb begin
    pend = iss_v_q;
    for (int i = 0; i < PIPE_LAT - 1; i++) begin
      pend = pend | trk_q[i].v;
    end
  end

  // Operand, issue and tracker next-state; hold freezes everything.
  always_comb begin
    rr_d      = rr_q;
    a_d       = a_q;
    d_d       = d_q;
    inm_d     = inm_q;
    iss_v_d   = iss_v_q;
    ced_d     = ced_q;
    iss_id_d  = iss_id_q;
    iss_tag_d = iss_tag_q;
    trk_d     = trk_q;
    if (!hold) begin
      iss_v_d   = gnt;
      ced_d     = gnt && (sel_op != 2'b00);
      iss_id_d  = gnt1;
      iss_tag_d = gnt1 ? req1_tag : req0_tag;
      trk_d[0]  = {iss_v_q, iss_id_q, iss_tag_q};
      for (int i = 1; i < PIPE_LAT; i++) begin
        trk_d[i] = trk_q[i-1];
      end
      if (gnt) begin
        rr_d  = gnt0;
        a_d   = gnt1 ? req1_a : req0_a;
        d_d   = gnt1 ? req1_d : req0_d;
        inm_d = op_inmode(sel_op);
      end
    end
  end

  // FSM next state; drain completes when nothing remains behind AMULT.
  always_comb begin
    state_d    = state_q;
    flush_done = 1'b0;
    if (!hold) begin
      unique case (state_q)
        IDLE: begin
          if (flush)    state_d = DRAIN;
          else if (gnt) state_d = RUN;
        end
        RUN: begin
          if (flush)              state_d = DRAIN;
          else if (!gnt && !pend) state_d = IDLE;
        end
        DRAIN: begin
          if (!pend) begin
            state_d    = IDLE;
            flush_done = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q   <= IDLE;
      rr_q      <= 1'b0;
      a_q       <= '0;
      d_q       <= '0;
      inm_q     <= '0;
      iss_v_q   <= 1'b0;
      ced_q     <= 1'b0;
      iss_id_q  <= 1'b0;
      iss_tag_q <= '0;
      trk_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      a_q       <= a_d;
      d_q       <= d_d;
      inm_q     <= inm_d;
      iss_v_q   <= iss_v_d;
      ced_q     <= ced_d;
      iss_id_q  <= iss_id_d;
      iss_tag_q <= iss_tag_d;
      trk_q     <= trk_d;
    end
  end

  assign A         = a_q;
  assign D         = d_q;
  assign INMODE    = inm_q;
  assign CEA2      = iss_v_q & ~hold;
  assign CED       = ced_q & ~hold;
  assign CEAD      = pend & ~hold;
  assign CEA1      = 1'b0;
  assign res_valid = trk_q[PIPE_LAT-1].v & ~hold;
  assign res_id    = trk_q[PIPE_LAT-1].id;
  assign res_tag   = trk_q[PIPE_LAT-1].tag;

`ifdef PREADD_ARB_STATS_EN
  logic [15:0] cnt0_q, cnt0_d;
  logic [15:0] cnt1_q, cnt1_d;

  // Saturating transfer counters per requester.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (gnt0 && cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
    if (gnt1 && cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (RST) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_preadd_arbiter_seq.sv
// tb_preadd_arbiter_seq: scoreboard bench for preadd_arbiter_seq.
// Directed scenarios followed by randomized traffic with hold/flush.
module tb_preadd_arbiter_seq;
  localparam int L  = 2;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          RST = 1'b1;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [29:0]   req0_a = '0, req1_a = '0;
  logic [24:0]   req0_d = '0, req1_d = '0;
  logic [1:0]    req0_op = '0, req1_op = '0;
  logic [TW-1:0] req0_tag = '0, req1_tag = '0;
  logic          hold = 1'b0, flush = 1'b0;
  logic          flush_done;
  logic [29:0]   A;
  logic [24:0]   D;
  logic [3:0]    INMODE;
  logic          CEA2, CED, CEAD, CEA1;
  logic          res_valid, res_id;
  logic [TW-1:0] res_tag;
`ifdef PREADD_ARB_STATS_EN
  logic [15:0]   grant_cnt0, grant_cnt1;
`endif

  preadd_arbiter_seq #(.PIPE_LAT(L), .TAG_W(TW)) dut (
    .clk(clk), .RST(RST),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_d(req0_d),
    .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_d(req1_d),
    .req1_op(req1_op), .req1_tag(req1_tag),
    .hold(hold), .flush(flush), .flush_done(flush_done),
    .A(A), .D(D), .INMODE(INMODE),
    .CEA2(CEA2), .CED(CED), .CEAD(CEAD), .CEA1(CEA1),
    .res_valid(res_valid), .res_id(res_id),
`ifdef PREADD_ARB_STATS_EN
    .res_tag(res_tag),
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`else
    .res_tag(res_tag)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int            iss;
    int            res;
    logic          id;
    logic [TW-1:0] tag;
  } rq_t;

  typedef struct {
    int   due;
    logic ced;
  } iq_t;

  rq_t         rq[$];
  iq_t         iq[$];
  int          act = 0;
  bit          mvalid = 0;
  logic        rr_m = 1'b0;
  bit          drain_m = 0;
  logic [29:0] a_m = '0;
  logic [24:0] d_m = '0;
  logic [3:0]  inm_m = '0;
  int          cnt_m0 = 0, cnt_m1 = 0;
  int          n_chk = 0, n_fail = 0;
  bit          stop = 0;

  function automatic logic [3:0] inmode_of(input logic [1:0] op);
    case (op)
      2'b00:   return 4'b0000;
      2'b01:   return 4'b0100;
      2'b10:   return 4'b1100;
      default: return 4'b0110;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model and scoreboard, evaluated mid-cycle.
  always @(negedge clk) begin
    logic g0, g1, acc;
    logic e_rv, e_cea2, e_ced, e_cead, e_fd, later;
    rq_t  r;
    iq_t  q;
    acc    = !hold && !flush && !drain_m;
    g0     = acc && req0_valid && (!req1_valid || !rr_m);
    g1     = acc && req1_valid && !g0;
    e_cea2 = !hold && iq.size() > 0 && iq[0].due == act;
    e_ced  = e_cea2 && iq[0].ced;
    e_rv   = !hold && rq.size() > 0 && rq[0].res == act;
    e_cead = 1'b0;
    later  = 1'b0;
    foreach (rq[k]) begin
      if (rq[k].iss <= act && rq[k].res > act) e_cead = 1'b1;
      if (rq[k].res > act) later = 1'b1;
    end
    e_cead = e_cead && !hold;
    e_fd   = drain_m && !hold && !later;
    if (mvalid) begin
      chk("req0_ready", 64'(req0_ready), 64'(g0));
      chk("req1_ready", 64'(req1_ready), 64'(g1));
      chk("CEA2", 64'(CEA2), 64'(e_cea2));
      chk("CED", 64'(CED), 64'(e_ced));
      chk("CEAD", 64'(CEAD), 64'(e_cead));
      chk("CEA1", 64'(CEA1), 64'(1'b0));
      chk("A", 64'(A), 64'(a_m));
      chk("D", 64'(D), 64'(d_m));
      chk("INMODE", 64'(INMODE), 64'(inm_m));
      chk("res_valid", 64'(res_valid), 64'(e_rv));
      chk("flush_done", 64'(flush_done), 64'(e_fd));
      if (e_rv) begin
        chk("res_id", 64'(res_id), 64'(rq[0].id));
        chk("res_tag", 64'(res_tag), 64'(rq[0].tag));
      end
`ifdef PREADD_ARB_STATS_EN
      chk("grant_cnt0", 64'(grant_cnt0), 64'(cnt_m0));
      chk("grant_cnt1", 64'(grant_cnt1), 64'(cnt_m1));
`endif
    end
    if (RST) begin
      rq.delete();
      iq.delete();
      rr_m    = 1'b0;
      drain_m = 0;
      a_m     = '0;
      d_m     = '0;
      inm_m   = '0;
      cnt_m0  = 0;
      cnt_m1  = 0;
      mvalid  = 1;
    end else if (mvalid && !hold) begin
      if (iq.size() > 0 && iq[0].due == act) void'(iq.pop_front());
      if (rq.size() > 0 && rq[0].res == act) void'(rq.pop_front());
      if (g0 || g1) begin
        q.due = act + 1;
        q.ced = (g1 ? req1_op : req0_op) != 2'b00;
        iq.push_back(q);
        r.iss = act + 1;
        r.res = act + 1 + L;
        r.id  = g1;
        r.tag = g1 ? req1_tag : req0_tag;
        rq.push_back(r);
        a_m   = g1 ? req1_a : req0_a;
        d_m   = g1 ? req1_d : req0_d;
        inm_m = inmode_of(g1 ? req1_op : req0_op);
        rr_m  = !g1;
        if (g0 && cnt_m0 < 65535) cnt_m0++;
        if (g1 && cnt_m1 < 65535) cnt_m1++;
      end
      if (drain_m && e_fd) drain_m = 0;
      else if (!drain_m && flush) drain_m = 1;
      act++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int r, input logic [29:0] a,
                      input logic [24:0] d, input logic [1:0] op,
                      input logic [TW-1:0] tag);
    bit g;
    int n;
    g = 0;
    n = 0;
    if (r == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_d = d;
      req0_op = op; req0_tag = tag;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_d = d;
      req1_op = op; req1_tag = tag;
    end
    while (!g && n < 300) begin
      @(negedge clk);
      g = (r == 0) ? req0_ready : req1_ready;
      @(posedge clk);
      #1;
      n++;
    end
    chk("send_accepted", 64'(g), 64'(1'b1));
    if (r == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  task automatic rand_req(input int r);
    while (!stop) begin
      if ($urandom_range(0, 2) == 0) idle(1);
      else send(r, 30'($urandom), 25'($urandom),
                2'($urandom), TW'($urandom));
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
    idle(1);
    send(0, 30'd5, 25'd7, 2'b01, 4'd3);
    idle(5);
    do_reset();
    fork
      begin
        send(0, 30'd11, 25'd12, 2'b01, 4'd1);
        send(0, 30'd13, 25'd14, 2'b10, 4'd2);
      end
      begin
        send(1, 30'd21, 25'd22, 2'b11, 4'd8);
        send(1, 30'd23, 25'd24, 2'b00, 4'd9);
      end
    join
    idle(5);
    send(0, 30'd100, 25'd101, 2'b00, 4'd4);
    send(0, 30'd102, 25'd103, 2'b10, 4'd5);
    send(0, 30'd104, 25'd105, 2'b11, 4'd6);
    idle(5);
    fork
      begin
        send(1, 30'd31, 25'd32, 2'b01, 4'd10);
        send(1, 30'd33, 25'd34, 2'b10, 4'd11);
        send(1, 30'd35, 25'd36, 2'b11, 4'd12);
      end
      begin
        repeat (3) @(posedge clk);
        #1 hold = 1'b1;
        idle(3);
        hold = 1'b0;
      end
    join
    idle(5);
    send(0, 30'd41, 25'd42, 2'b01, 4'd1);
    send(0, 30'd43, 25'd44, 2'b10, 4'd2);
    flush = 1'b1;
    fork
      send(0, 30'd45, 25'd46, 2'b11, 4'd7);
      begin
        idle(2);
        flush = 1'b0;
      end
    join
    idle(5);
    send(1, 30'd51, 25'd52, 2'b01, 4'd13);
    idle(1);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    idle(4);
    fork
      rand_req(0);
      rand_req(1);
      begin
        repeat (300) begin
          @(posedge clk);
          #1;
          hold  = ($urandom_range(0, 7) == 0);
          flush = ($urandom_range(0, 19) == 0);
        end
        hold  = 1'b0;
        flush = 1'b0;
        stop  = 1;
      end
    join
    hold  = 1'b0;
    flush = 1'b0;
    idle(10);
    chk("scoreboard_empty", 64'(rq.size() + iq.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/preadd_arbiter_seq.md
Name: preadd_arbiter_seq

Overview:
- Arbitrates two requesters onto one shared A/D pre-adder datapath (dual A register, D register, AD register).
- Drives the pre-adder's A and D operands, INMODE and clock enables.
- Tracks in-flight operations through the fixed pipeline and tags each result with its requester ID and a user tag.
- Sits between the upstream op sources and the DSP slice input stage.

Parameters:
- PIPE_LAT, 2, cycles from issue to AMULT valid (A2 reg + AD reg); legal 1..4.
- TAG_W, 4, width of user tag carried alongside each op.

Ports:
- clk  in  1  clock.
- RST  in  1  synchronous active-high reset.
- req0_valid  in  1  requester 0 has an op.
- req0_ready  out  1  requester 0 op accepted this cycle.
- req0_a  in  30  A operand, requester 0.
- req0_d  in  25  D operand, requester 0.
- req0_op  in  2  op code: 00 A, 01 D+A, 10 D-A, 11 D.
- req0_tag  in  TAG_W  user tag, requester 0.
- req1_*  (same set as req0_*)  requester 1.
- hold  in  1  freeze the whole datapath.
- flush  in  1  stop accepting, drain the pipeline.
- flush_done  out  1  one-cycle pulse when the drain completes.
- A  out  30  to pre-adder A.
- D  out  25  to pre-adder D.
- INMODE  out  4  to pre-adder.
- CEA2  out  1  A2 register enable.
- CED  out  1  D register enable.
- CEAD  out  1  AD register enable.
- CEA1  out  1  A1 register enable; tied 0.
- res_valid  out  1  AMULT holds a valid result this cycle.
- res_id  out  1  requester of that result.
- res_tag  out  TAG_W  tag of that result.

Behaviour:
- Reset (RST=1 at clk edge), all outputs 0:
  - state=IDLE, tracker cleared, rr pointer=0.
  - INMODE=0, A=0, D=0, all CEs 0, res_valid=0, flush_done=0.
- Op to INMODE mapping. INMODE[0] is always 0 (A2 path).
  - 00 -> 4'b0000
  - 01 -> 4'b0100
  - 10 -> 4'b1100
  - 11 -> 4'b0110
- Operand registers: A, D and INMODE are registered outputs, loaded on a grant.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on any req_valid with hold=0 and flush=0.
  - RUN -> IDLE when no request is granted and the tracker is empty.
  - RUN or IDLE -> DRAIN on flush=1.
  - DRAIN -> IDLE when the tracker is empty; flush_done pulses in that same cycle.
  - flush asserted with the tracker already empty: enter DRAIN, then exit on the next cycle with flush_done.
- Arbitration: round-robin.
  - At most one grant per cycle, only in IDLE/RUN with hold=0.
  - Both valid: grant requester rr; rr toggles to the other requester after each grant.
  - Only one valid: grant it; rr moves to the other.
  - req_ready is combinational, equal to the grant; transfer = valid & ready.
  - A requester must hold its valid and payload until ready.
- Issue cycle (registered, cycle after grant):
  - CEA2=1, CED=1 if op uses D (01/10/11) else 0.
  - CEAD=1 while any op is in flight or issuing.
- Tracker: PIPE_LAT-deep shift register of {valid,id,tag}.
  - Entry inserted at issue.
  - Entry output drives res_valid/res_id/res_tag PIPE_LAT cycles after the issue cycle.
  - Back-to-back grants give one result per cycle.
- hold=1:
  - No grants, all CEs 0, tracker frozen, res_valid forced 0.
  - On release, the tracker resumes exactly; no ops are lost or duplicated.
- hold and flush together: hold has priority; the drain pauses.
- RST mid-operation discards in-flight ops; no res_valid is produced for them.

Optional Feature:
- Macro: PREADD_ARB_STATS_EN.
- Defined: adds outputs grant_cnt0 and grant_cnt1 (16 bits each), one per requester.
  - Each increments on its requester's transfer and saturates at 16'hFFFF.
  - Cleared by RST.
- Undefined: ports and counters are absent; other behaviour is identical.

Test Plan:
- Single op, A+D: req0 A=30'd5, D=25'd7, op=01, tag=3.
  - Issue cycle after the grant: INMODE=4'b0100, CED=1.
  - res_valid=1, res_id=0, res_tag=3 exactly PIPE_LAT=2 cycles after issue.
- Contention: both requesters valid for 4 cycles.
  - Grants alternate 0,1,0,1.
  - res_id sequence 0,1,0,1 on consecutive cycles.
- Op mapping: issue op 00, 10, 11 back-to-back.
  - INMODE = 0000, 1100, 0110.
  - CED = 0, 1, 1.
- Hold: hold=1 for 3 cycles after the second of 3 back-to-back issues.
  - CEs 0 and no res_valid during hold.
  - After release, the remaining results appear in order with correct tags.
- Flush: flush=1 with 2 ops in flight and req0 valid.
  - req0_ready stays 0.
  - flush_done pulses with the last res_valid.
  - State returns to IDLE.
- Reset mid-flight: RST at the cycle after issue.
  - All outputs 0 next cycle; no res_valid for the dropped op.
  - With PREADD_ARB_STATS_EN, counters read 0.
